ttt_move_gen: RTL and testbench

Computer-opponent move generator for the tic-tac-toe engine. It snapshots the 9-cell board on request and scans it with a fixed priority: win, block, centre, corner, edge. It then offers the chosen 1-based position over a valid/ack handshake. It sits in front of the engine's computer-move input, so the computer side needs no external stimulus.

---
 rtl/ttt_move_gen.sv | 194 +++++++++++++++++++
 tb/tb_ttt_move_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ttt_move_gen.sv
// rtl/ttt_move_gen.sv - tic-tac-toe computer move generator (win/block/centre/corner/edge)
//
// Snapshots the board on req, scans it one candidate per cycle with a fixed
// priority and offers the chosen 1-based position over a valid/ack handshake.
//
// Ports:
//   clk        - clock, all state changes on posedge
//   rst_n      - asynchronous active-low reset
//   board      - 9 cells x 2 bits, cell k at board[2k+1:2k]
//                (00 empty, 01 player O, 10 computer X, 11 occupied/neutral)
//   req        - start a scan (sampled in IDLE only)
//   move_ack   - consumer accepts the offered move (sampled in OFFER only)
//   move_valid - move offered
//   move_pos   - chosen position 1..9, 0 when cleared
//   busy       - high whenever not IDLE
//   no_move    - one-cycle pulse when the board has no empty cell
//
// Parameter THINK_DELAY (0..15): idle cycles between selection and offer.
// Macro MOVEGEN_BLOCK_EN: compiles in the BLOCK phase (player threat blocking).

module ttt_move_gen #(
  parameter int THINK_DELAY = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [17:0] board,
  input  logic        req,
  input  logic        move_ack,
  output logic        move_valid,
  output logic [3:0]  move_pos,
  output logic        busy,
  output logic        no_move
);

  typedef enum logic [2:0] {
    S_IDLE, S_WIN, S_BLOCK, S_CENTER, S_CORNER, S_EDGE, S_DELAY, S_OFFER
  } state_t;

  // DELAY counts down to zero, so it is loaded with one less than the wait.
  localparam logic [3:0] DELAY_INIT = (THINK_DELAY > 0) ? 4'(THINK_DELAY - 1) : 4'd0;

  state_t      state, state_nxt;
  logic [17:0] snap;
  logic [2:0]  idx;
  logic [3:0]  cnt;
  logic        found;
  logic [3:0]  found_cell;
  state_t      sel_state;

  function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] k);
    return b[2*k +: 2];
  endfunction

  function automatic logic [11:0] line_cells(input logic [2:0] l);
    case (l)
      3'd0:    return {4'd0, 4'd1, 4'd2};
      3'd1:    return {4'd3, 4'd4, 4'd5};
      3'd2:    return {4'd6, 4'd7, 4'd8};
      3'd3:    return {4'd0, 4'd3, 4'd6};
      3'd4:    return {4'd1, 4'd4, 4'd7};
      3'd5:    return {4'd2, 4'd5, 4'd8};
      3'd6:    return {4'd0, 4'd4, 4'd8};
      default: return {4'd2, 4'd4, 4'd6};
    endcase
  endfunction

  // Hit when two cells hold `who` and the third is empty; returns {hit, empty cell}.
  function automatic logic [4:0] line_check(input logic [17:0] b, input logic [2:0] l,
                                            input logic [1:0] who);
    logic [11:0] lc;
    logic [1:0]  a, m, z;
    lc = line_cells(l);
    a  = cell_of(b, lc[11:8]);
    m  = cell_of(b, lc[7:4]);
    z  = cell_of(b, lc[3:0]);
    if (m == who && z == who && a == 2'b00) return {1'b1, lc[11:8]};
    if (a == who && z == who && m == 2'b00) return {1'b1, lc[7:4]};
    if (a == who && m == who && z == 2'b00) return {1'b1, lc[3:0]};
    return 5'd0;
  endfunction

  // Candidate evaluation for the current scan step.
  always_comb begin
    logic [3:0] corner;
    found      = 1'b0;
    found_cell = 4'd0;
    corner     = 4'd0;
    case (idx[1:0])
      2'd0:    corner = 4'd0;
      2'd1:    corner = 4'd2;
      2'd2:    corner = 4'd6;
      default: corner = 4'd8;
    endcase
    case (state)
      S_WIN:    {found, found_cell} = line_check(snap, idx, 2'b10);
`ifdef MOVEGEN_BLOCK_EN
      S_BLOCK:  {found, found_cell} = line_check(snap, idx, 2'b01);
`endif
      S_CENTER: begin
        found      = (cell_of(snap, 4'd4) == 2'b00);
        found_cell = 4'd4;
      end
      S_CORNER: begin
        found      = (cell_of(snap, corner) == 2'b00);
        found_cell = corner;
      end
      S_EDGE: begin
        // Edge cells 1,3,5,7 are the odd indices.
        found_cell = {1'b0, idx[1:0], 1'b1};
        found      = (cell_of(snap, found_cell) == 2'b00);
      end
      default: ;
    endcase
  end

  assign sel_state = (THINK_DELAY == 0) ? S_OFFER : S_DELAY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req) state_nxt = S_WIN;
      S_WIN: begin
        if (found) state_nxt = sel_state;
`ifdef MOVEGEN_BLOCK_EN
        else if (idx == 3'd7) state_nxt = S_BLOCK;
`else
        else if (idx == 3'd7) state_nxt = S_CENTER;
`endif
      end
`ifdef MOVEGEN_BLOCK_EN
      S_BLOCK: begin
        if (found) state_nxt = sel_state;
        else if (idx == 3'd7) state_nxt = S_CENTER;
      end
`endif
      S_CENTER: state_nxt = found ? sel_state : S_CORNER;
      S_CORNER: begin
        if (found) state_nxt = sel_state;
        else if (idx[1:0] == 2'd3) state_nxt = S_EDGE;
      end
      S_EDGE: begin
        if (found) state_nxt = sel_state;
        else if (idx[1:0] == 2'd3) state_nxt = S_IDLE;
      end
      S_DELAY:  if (cnt == 4'd0) state_nxt = S_OFFER;
      S_OFFER:  if (move_ack) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    move_valid = (state == S_OFFER);
    busy       = (state != S_IDLE);
  end

  // Datapath: snapshot, scan index, delay counter, move register, no_move pulse.
  // The index simply keeps counting through phases: the 3-bit wrap after L7
  // and the low two bits for corner/edge give each phase a start at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap     <= '0;
      idx      <= '0;
      cnt      <= '0;
      move_pos <= '0;
      no_move  <= 1'b0;
    end else begin
      no_move <= 1'b0;
      case (state)
        S_IDLE: if (req) begin
          snap <= board;
          idx  <= '0;
        end
        S_WIN, S_BLOCK, S_CENTER, S_CORNER, S_EDGE: begin
          if (found) begin
            move_pos <= found_cell + 4'd1;
            cnt      <= DELAY_INIT;
          end else begin
            if (state != S_CENTER) idx <= idx + 3'd1;
            if (state == S_EDGE && idx[1:0] == 2'd3) no_move <= 1'b1;
          end
        end
        S_DELAY: cnt <= cnt - 4'd1;
        S_OFFER: if (move_ack) move_pos <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_move_gen.sv
// tb/tb_ttt_move_gen.sv - scoreboard bench for ttt_move_gen (THINK_DELAY 0 and 3)

module tb_ttt_move_gen;

  typedef struct {
    int pos;
    int lat;
    bit none;
    int start;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] board_s [2];
  logic        req_s   [2];
  logic        ack_s   [2];
  logic        mv0, mv1, bz0, bz1, nm0, nm1;
  logic [3:0]  mp0, mp1;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        q0[$];
  exp_t        q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ttt_move_gen #(.THINK_DELAY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .board(board_s[0]), .req(req_s[0]), .move_ack(ack_s[0]),
    .move_valid(mv0), .move_pos(mp0), .busy(bz0), .no_move(nm0));

  ttt_move_gen #(.THINK_DELAY(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .board(board_s[1]), .req(req_s[1]), .move_ack(ack_s[1]),
    .move_valid(mv1), .move_pos(mp1), .busy(bz1), .no_move(nm1));

  function automatic int td(input int u);
    return (u == 0) ? 0 : 3;
  endfunction
  function automatic logic g_mv(input int u); return (u == 0) ? mv0 : mv1; endfunction
  function automatic logic g_bz(input int u); return (u == 0) ? bz0 : bz1; endfunction
  function automatic logic g_nm(input int u); return (u == 0) ? nm0 : nm1; endfunction
  function automatic int   g_mp(input int u); return (u == 0) ? int'(mp0) : int'(mp1); endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: rules applied directly to the 9 cells; latency counts edges after edge 0.
  function automatic exp_t model(input logic [17:0] b, input int tdly);
    exp_t e;
    int c[9];
    int lines[8][3];
    int corners[4];
    int edges[4];
    int nph, base, own, emp, ec, who;
    lines   = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    corners = '{0, 2, 6, 8};
    edges   = '{1, 3, 5, 7};
    for (int k = 0; k < 9; k++) c[k] = int'(b[2*k +: 2]);
    e.pos = 0; e.lat = 0; e.none = 1'b0; e.start = 0;
`ifdef MOVEGEN_BLOCK_EN
    nph = 2;
`else
    nph = 1;
`endif
    for (int p = 0; p < nph; p++) begin
      who = (p == 0) ? 2 : 1;
      for (int l = 0; l < 8; l++) begin
        own = 0; emp = 0; ec = 0;
        for (int j = 0; j < 3; j++) begin
          if (c[lines[l][j]] == who) own++;
          else if (c[lines[l][j]] == 0) begin emp++; ec = lines[l][j]; end
        end
        if (own == 2 && emp == 1) begin
          e.pos = ec + 1; e.lat = 1 + 8*p + l + tdly;
          return e;
        end
      end
    end
    base = 1 + 8*nph;
    if (c[4] == 0) begin e.pos = 5; e.lat = base + tdly; return e; end
    for (int i = 0; i < 4; i++)
      if (c[corners[i]] == 0) begin e.pos = corners[i] + 1; e.lat = base + 1 + i + tdly; return e; end
    for (int i = 0; i < 4; i++)
      if (c[edges[i]] == 0) begin e.pos = edges[i] + 1; e.lat = base + 5 + i + tdly; return e; end
    e.none = 1'b1; e.lat = base + 8;
    return e;
  endfunction

  function automatic logic [17:0] pick_board(input int t);
    logic [17:0] b;
    int r;
    b = '0;
    case (t)
      0: b = 18'h0;                        // empty board
      1: b = 18'h0014A;                    // X at 1,2; O at 4,5
      2: b = 18'h05200;                    // O at 7,8; X at 5
      3: for (int k = 0; k < 9; k++) b[2*k +: 2] = 2'($urandom_range(1, 3));
      default: begin
        if ($urandom_range(0, 7) == 0)
          for (int k = 0; k < 9; k++) b[2*k +: 2] = 2'($urandom_range(1, 3));
        else
          for (int k = 0; k < 9; k++) begin
            r = $urandom_range(0, 9);
            b[2*k +: 2] = (r < 4) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
          end
      end
    endcase
    return b;
  endfunction

  task automatic monitor(input int u);
    logic   pmv, pnm;
    int     pmp, lat;
    exp_t   e;
    pmv = 1'b0; pnm = 1'b0; pmp = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin pmv = 1'b0; pnm = 1'b0; continue; end
      if (g_mv(u) && pmv) chk($sformatf("u%0d pos_stable", u), g_mp(u), pmp);
      if (g_nm(u) && pnm) chk($sformatf("u%0d no_move_width", u), 2, 1);
      if ((g_mv(u) && !pmv) || (g_nm(u) && !pnm)) begin
        if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
          chk($sformatf("u%0d unexpected_output", u), 1, 0);
        end else begin
          e = (u == 0) ? q0.pop_front() : q1.pop_front();
          lat = cyc - e.start - 1;
          chk($sformatf("u%0d no_move", u), int'(g_nm(u)), int'(e.none));
          chk($sformatf("u%0d latency", u), lat, e.lat);
          if (e.none) begin
            chk($sformatf("u%0d busy_at_no_move", u), int'(g_bz(u)), 0);
            chk($sformatf("u%0d valid_at_no_move", u), int'(g_mv(u)), 0);
          end else begin
            chk($sformatf("u%0d move_pos", u), g_mp(u), e.pos);
          end
        end
      end
      pmv = g_mv(u); pnm = g_nm(u); pmp = g_mp(u);
    end
  endtask

  task automatic driver(input int u, input int n);
    exp_t e;
    int   w;
    bit   done;
    for (int t = 0; t < n; t++) begin
      w = 0;
      @(negedge clk);
      while (g_bz(u) && w < 100) begin @(negedge clk); w++; end
      board_s[u] = pick_board(t);
      req_s[u]   = 1'b1;
      ack_s[u]   = 1'b0;
      e = model(board_s[u], td(u));
      e.start = cyc;
      if (u == 0) q0.push_back(e); else q1.push_back(e);
      @(negedge clk);
      done = 1'b0;
      for (int k = 0; k < 60; k++) begin
        if (g_mv(u) || g_nm(u)) begin done = 1'b1; break; end
        // Scribble on all inputs mid-scan; none of it may reach the result.
        board_s[u] = 18'($urandom);
        req_s[u]   = 1'($urandom);
        ack_s[u]   = 1'($urandom);
        @(negedge clk);
      end
      req_s[u] = 1'b0;
      ack_s[u] = 1'b0;
      if (!done) begin
        chk($sformatf("u%0d timeout", u), 0, 1);
        if (u == 0) q0.delete(); else q1.delete();
        continue;
      end
      if (g_mv(u)) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        ack_s[u] = 1'b1;
        req_s[u] = 1'($urandom);
        @(negedge clk);
        ack_s[u] = 1'b0;
        req_s[u] = 1'b0;
        chk($sformatf("u%0d valid_after_ack", u), int'(g_mv(u)), 0);
        chk($sformatf("u%0d pos_after_ack", u), g_mp(u), 0);
        chk($sformatf("u%0d busy_after_ack", u), int'(g_bz(u)), 0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin board_s[u] = '0; req_s[u] = 1'b0; ack_s[u] = 1'b0; end
    repeat (2) @(negedge clk);
    chk("reset valid", int'(mv0) + int'(mv1), 0);
    chk("reset pos", g_mp(0) + g_mp(1), 0);
    chk("reset busy", int'(bz0) + int'(bz1), 0);
    chk("reset no_move", int'(nm0) + int'(nm1), 0);
    rst_n = 1'b1;
    fork
      monitor(0);
      monitor(1);
    join_none
    fork
      driver(0, 40);
      driver(1, 40);
    join

    // Reset mid-scan: empty board on the THINK_DELAY=3 unit, reset after edge 5.
    @(negedge clk);
    board_s[1] = '0;
    req_s[1]   = 1'b1;
    @(negedge clk);
    req_s[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst busy_before", int'(bz1), 1);
    rst_n = 1'b0;
    #1;
    chk("rst busy", int'(bz1), 0);
    chk("rst valid", int'(mv1), 0);
    chk("rst pos", g_mp(1), 0);
    chk("rst no_move", int'(nm1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      chk("post_rst idle", int'(bz1) + int'(mv1) + int'(nm1), 0);
    end
    chk("q0 drained", q0.size(), 0);
    chk("q1 drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
